// File: rtl/cv32e40p_rf_shadow_pkg.sv
// Shared types and constants for the RF shadow/restore engine.
// The optional parity feature is enabled with CV32E40P_RF_SHADOW_PARITY_EN.
package cv32e40p_rf_shadow_pkg;

  localparam int unsigned REGFILE_NUM_REGS   = 64;
  localparam int unsigned REGFILE_ADDR_WIDTH = 6;
  localparam int unsigned REGFILE_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESTORE = 2'd1,
    DONE    = 2'd2
  } rf_shadow_state_e;

endpackage

// File: rtl/cv32e40p_rf_shadow_mem.sv
// Two-write/two-read shadow flop array; port B wins on a same-address write, x0 is never written.
// With CV32E40P_RF_SHADOW_PARITY_EN each entry carries an even-parity bit checked on read.
module cv32e40p_rf_shadow_mem
  import cv32e40p_rf_shadow_pkg::*;
#(
  parameter int unsigned NUM_REGS   = REGFILE_NUM_REGS,
  parameter int unsigned ADDR_WIDTH = REGFILE_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = REGFILE_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_a_i,
  input  logic [ADDR_WIDTH-1:0] waddr_a_i,
  input  logic [DATA_WIDTH-1:0] wdata_a_i,
  input  logic                  we_b_i,
  input  logic [ADDR_WIDTH-1:0] waddr_b_i,
  input  logic [DATA_WIDTH-1:0] wdata_b_i,
  input  logic [ADDR_WIDTH-1:0] raddr_a_i,
  input  logic [ADDR_WIDTH-1:0] raddr_b_i,
  output logic [DATA_WIDTH-1:0] rdata_a_o,
  output logic [DATA_WIDTH-1:0] rdata_b_o
`ifdef CV32E40P_RF_SHADOW_PARITY_EN
  ,
  output logic                  perr_a_o,
  output logic                  perr_b_o
`endif
);

`ifdef CV32E40P_RF_SHADOW_PARITY_EN
  localparam int unsigned ENTRY_WIDTH = DATA_WIDTH + 1;
`else
  localparam int unsigned ENTRY_WIDTH = DATA_WIDTH;
`endif

  logic [ENTRY_WIDTH-1:0] mem_q [NUM_REGS];
  logic [ENTRY_WIDTH-1:0] entry_a;
  logic [ENTRY_WIDTH-1:0] entry_b;

`ifdef CV32E40P_RF_SHADOW_PARITY_EN
  assign entry_a = {^wdata_a_i, wdata_a_i};
  assign entry_b = {^wdata_b_i, wdata_b_i};
`else
  assign entry_a = wdata_a_i;
  assign entry_b = wdata_b_i;
`endif

  // Port B is written last so it overrides port A on a collision.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (we_a_i && (waddr_a_i != '0)) begin
        mem_q[waddr_a_i] <= entry_a;
      end
      if (we_b_i && (waddr_b_i != '0)) begin
        mem_q[waddr_b_i] <= entry_b;
      end
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i][DATA_WIDTH-1:0];
  assign rdata_b_o = mem_q[raddr_b_i][DATA_WIDTH-1:0];

`ifdef CV32E40P_RF_SHADOW_PARITY_EN
  assign perr_a_o = ^mem_q[raddr_a_i];
  assign perr_b_o = ^mem_q[raddr_b_i];
`endif

endmodule

// File: rtl/cv32e40p_rf_shadow_restore.sv
// RF shadow/restore engine: mirrors core RF writes in IDLE and replays them two per cycle on request.
// Defining CV32E40P_RF_SHADOW_PARITY_EN adds per-entry parity and a sticky parity_err_o output.
module cv32e40p_rf_shadow_restore
  import cv32e40p_rf_shadow_pkg::*;
#(
  parameter int unsigned NUM_REGS   = REGFILE_NUM_REGS,
  parameter int unsigned ADDR_WIDTH = REGFILE_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = REGFILE_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  core_we_a_i,
  input  logic [ADDR_WIDTH-1:0] core_waddr_a_i,
  input  logic [DATA_WIDTH-1:0] core_wdata_a_i,
  input  logic                  core_we_b_i,
  input  logic [ADDR_WIDTH-1:0] core_waddr_b_i,
  input  logic [DATA_WIDTH-1:0] core_wdata_b_i,
  input  logic                  restore_req_i,
  output logic                  recover_o,
  output logic                  rf_we_a_o,
  output logic [ADDR_WIDTH-1:0] rf_waddr_a_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_a_o,
  output logic                  rf_we_b_o,
  output logic [ADDR_WIDTH-1:0] rf_waddr_b_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_b_o,
  output logic                  busy_o,
  output logic                  done_o
`ifdef CV32E40P_RF_SHADOW_PARITY_EN
  ,
  output logic                  parity_err_o
`endif
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 2);

  rf_shadow_state_e      state_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [ADDR_WIDTH-1:0] raddr_a;
  logic [ADDR_WIDTH-1:0] raddr_b;
  logic [DATA_WIDTH-1:0] rdata_a;
  logic [DATA_WIDTH-1:0] rdata_b;
  logic [DATA_WIDTH-1:0] next_data_a;
  logic [DATA_WIDTH-1:0] next_data_b;
  logic                  fwd_a;
  logic                  fwd_b;
  logic                  mirror_en;
  logic                  load_next;

  assign mirror_en = (state_q == IDLE);
  assign load_next = (mirror_en && restore_req_i) ||
                     ((state_q == RESTORE) && (idx_q != LAST_IDX));
  assign raddr_a   = mirror_en ? '0 : (idx_q + ADDR_WIDTH'(2));
  assign raddr_b   = raddr_a | ADDR_WIDTH'(1);

`ifdef CV32E40P_RF_SHADOW_PARITY_EN
  logic perr_a;
  logic perr_b;
  logic parity_err_q;
  assign parity_err_o = parity_err_q;
`endif

  cv32e40p_rf_shadow_mem #(
    .NUM_REGS   (NUM_REGS),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .we_a_i    (core_we_a_i && mirror_en),
    .waddr_a_i (core_waddr_a_i),
    .wdata_a_i (core_wdata_a_i),
    .we_b_i    (core_we_b_i && mirror_en),
    .waddr_b_i (core_waddr_b_i),
    .wdata_b_i (core_wdata_b_i),
    .raddr_a_i (raddr_a),
    .raddr_b_i (raddr_b),
    .rdata_a_o (rdata_a),
    .rdata_b_o (rdata_b)
`ifdef CV32E40P_RF_SHADOW_PARITY_EN
    ,
    .perr_a_o  (perr_a),
    .perr_b_o  (perr_b)
`endif
  );

  // A core write landing on the same edge that starts a restore has not reached the array yet,
  // so forward it into the first replay beat (port B priority, x0 excluded).
  always_comb begin
    next_data_a = rdata_a;
    next_data_b = rdata_b;
    fwd_a       = 1'b0;
    fwd_b       = 1'b0;
    if (mirror_en) begin
      if (core_we_a_i && (core_waddr_a_i == raddr_a) && (raddr_a != '0)) begin
        next_data_a = core_wdata_a_i;
        fwd_a       = 1'b1;
      end
      if (core_we_b_i && (core_waddr_b_i == raddr_a) && (raddr_a != '0)) begin
        next_data_a = core_wdata_b_i;
        fwd_a       = 1'b1;
      end
      if (core_we_a_i && (core_waddr_a_i == raddr_b)) begin
        next_data_b = core_wdata_a_i;
        fwd_b       = 1'b1;
      end
      if (core_we_b_i && (core_waddr_b_i == raddr_b)) begin
        next_data_b = core_wdata_b_i;
        fwd_b       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      recover_o    <= 1'b0;
      rf_we_a_o    <= 1'b0;
      rf_waddr_a_o <= '0;
      rf_wdata_a_o <= '0;
      rf_we_b_o    <= 1'b0;
      rf_waddr_b_o <= '0;
      rf_wdata_b_o <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_o <= 1'b0;
          if (restore_req_i) begin
            state_q   <= RESTORE;
            idx_q     <= '0;
            recover_o <= 1'b1;
            busy_o    <= 1'b1;
            rf_we_a_o <= 1'b1;
            rf_we_b_o <= 1'b1;
          end
        end
        RESTORE: begin
          if (idx_q == LAST_IDX) begin
            state_q   <= DONE;
            recover_o <= 1'b0;
            rf_we_a_o <= 1'b0;
            rf_we_b_o <= 1'b0;
            done_o    <= 1'b1;
          end else begin
            idx_q <= raddr_a;
          end
        end
        DONE: begin
          state_q <= IDLE;
          idx_q   <= '0;
          done_o  <= 1'b0;
          busy_o  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase

      if (load_next) begin
        rf_waddr_a_o <= raddr_a;
        rf_wdata_a_o <= next_data_a;
        rf_waddr_b_o <= raddr_b;
        rf_wdata_b_o <= next_data_b;
      end else if (state_q == RESTORE) begin
        rf_waddr_a_o <= '0;
        rf_wdata_a_o <= '0;
        rf_waddr_b_o <= '0;
        rf_wdata_b_o <= '0;
      end
    end
  end

`ifdef CV32E40P_RF_SHADOW_PARITY_EN
  // Sticky until reset; forwarded data bypasses the array so it cannot be corrupt.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      parity_err_q <= 1'b0;
    end else if (load_next && ((perr_a && !fwd_a) || (perr_b && !fwd_b))) begin
      parity_err_q <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cv32e40p_rf_shadow_restore.sv
// Scoreboard bench for cv32e40p_rf_shadow_restore; parity scenario built with CV32E40P_RF_SHADOW_PARITY_EN.
module tb_cv32e40p_rf_shadow_restore;

  localparam int NR = 64;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        core_we_a_i = 1'b0;
  logic [5:0]  core_waddr_a_i = '0;
  logic [31:0] core_wdata_a_i = '0;
  logic        core_we_b_i = 1'b0;
  logic [5:0]  core_waddr_b_i = '0;
  logic [31:0] core_wdata_b_i = '0;
  logic        restore_req_i = 1'b0;
  logic        recover_o, rf_we_a_o, rf_we_b_o, busy_o, done_o;
  logic [5:0]  rf_waddr_a_o, rf_waddr_b_o;
  logic [31:0] rf_wdata_a_o, rf_wdata_b_o;
`ifdef CV32E40P_RF_SHADOW_PARITY_EN
  logic        parity_err_o;
`endif

  cv32e40p_rf_shadow_restore dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .core_we_a_i    (core_we_a_i),
    .core_waddr_a_i (core_waddr_a_i),
    .core_wdata_a_i (core_wdata_a_i),
    .core_we_b_i    (core_we_b_i),
    .core_waddr_b_i (core_waddr_b_i),
    .core_wdata_b_i (core_wdata_b_i),
    .restore_req_i  (restore_req_i),
    .recover_o      (recover_o),
    .rf_we_a_o      (rf_we_a_o),
    .rf_waddr_a_o   (rf_waddr_a_o),
    .rf_wdata_a_o   (rf_wdata_a_o),
    .rf_we_b_o      (rf_we_b_o),
    .rf_waddr_b_o   (rf_waddr_b_o),
    .rf_wdata_b_o   (rf_wdata_b_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
`ifdef CV32E40P_RF_SHADOW_PARITY_EN
    ,
    .parity_err_o   (parity_err_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [5:0]  aa;
    logic [31:0] da;
    logic [5:0]  ab;
    logic [31:0] db;
  } beat_t;

  beat_t       exp_q [$];
  logic [31:0] model [NR];
  int          total = 0;
  int          bad = 0;
  int          rec_n, busy_n, done_n;
  logic [5:0]  cap_aa [32];
  logic [31:0] cap_da [32];
  logic [5:0]  cap_ab [32];
  logic [31:0] cap_db [32];

  // Replay scoreboard: every driven beat must match the next expected one.
  always @(negedge clk_i) begin
    beat_t got, exp;
    if (rst_ni && rf_we_a_o) begin
      got = {rf_waddr_a_o, rf_wdata_a_o, rf_waddr_b_o, rf_wdata_b_o};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("[TB] FAIL replay_unexpected got=%h expected=none", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp || rf_we_b_o !== 1'b1) begin
          bad++;
          $display("[TB] FAIL replay_beat got=%h we_b=%b expected=%h we_b=1", got, rf_we_b_o, exp);
        end
      end
    end
  end

  task automatic model_upd(input logic wa, input logic [5:0] aa, input logic [31:0] da,
                           input logic wb, input logic [5:0] ab, input logic [31:0] db);
    if (wa && aa != 0) model[aa] = da;
    if (wb && ab != 0) model[ab] = db;
  endtask

  task automatic drive_core(input logic wa, input logic [5:0] aa, input logic [31:0] da,
                            input logic wb, input logic [5:0] ab, input logic [31:0] db);
    core_we_a_i = wa; core_waddr_a_i = aa; core_wdata_a_i = da;
    core_we_b_i = wb; core_waddr_b_i = ab; core_wdata_b_i = db;
  endtask

  task automatic push_restore();
    for (int i = 0; i < NR / 2; i++)
      exp_q.push_back({6'(2 * i), model[2 * i], 6'(2 * i + 1), model[2 * i + 1]});
  endtask

  task automatic core_write(input logic wa, input logic [5:0] aa, input logic [31:0] da,
                            input logic wb, input logic [5:0] ab, input logic [31:0] db);
    drive_core(wa, aa, da, wb, ab, db);
    model_upd(wa, aa, da, wb, ab, db);
    @(posedge clk_i); #1;
    drive_core(0, 0, 0, 0, 0, 0);
  endtask

  // Pulses restore_req_i (optionally with a concurrent core write) and observes 36 cycles.
  task automatic run_restore(input logic wa, input logic [5:0] aa, input logic [31:0] da,
                             input logic wb, input logic [5:0] ab, input logic [31:0] db,
                             input int ignore_at);
    restore_req_i = 1'b1;
    drive_core(wa, aa, da, wb, ab, db);
    model_upd(wa, aa, da, wb, ab, db);
    push_restore();
    @(posedge clk_i); #1;
    restore_req_i = 1'b0;
    drive_core(0, 0, 0, 0, 0, 0);
    rec_n = 0; busy_n = 0; done_n = 0;
    for (int c = 0; c < 36; c++) begin
      @(negedge clk_i);
      if (recover_o) rec_n++;
      if (busy_o) busy_n++;
      if (done_o) done_n++;
      if (c < 32) begin
        cap_aa[c] = rf_waddr_a_o; cap_da[c] = rf_wdata_a_o;
        cap_ab[c] = rf_waddr_b_o; cap_db[c] = rf_wdata_b_o;
      end
      if (c == ignore_at) begin
        restore_req_i = 1'b1;
        drive_core(1, 6'd9, 32'hBAD0_0009, 0, 0, 0);
      end else if (c == ignore_at + 1) begin
        restore_req_i = 1'b0;
        drive_core(0, 0, 0, 0, 0, 0);
      end
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk_i);
    #1;
    total++;
    if ({recover_o, rf_we_a_o, rf_waddr_a_o, rf_wdata_a_o, rf_we_b_o, rf_waddr_b_o,
         rf_wdata_b_o, busy_o, done_o} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_outputs got rec=%b we=%b%b busy=%b done=%b expected all 0",
               recover_o, rf_we_a_o, rf_we_b_o, busy_o, done_o);
    end
    rst_ni = 1'b1;
    repeat (5) @(posedge clk_i);
    @(negedge clk_i);
    total++;
    if ({recover_o, rf_we_a_o, rf_we_b_o, busy_o, done_o} !== 5'b0) begin
      bad++;
      $display("[TB] FAIL idle_outputs got %b expected 00000",
               {recover_o, rf_we_a_o, rf_we_b_o, busy_o, done_o});
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_mirror();
    core_write(1, 6'd5, 32'hDEADBEEF, 1, 6'd6, 32'h12345678);
    run_restore(0, 0, 0, 0, 0, 0, -1);
    total++;
    if ({cap_aa[2], cap_da[2], cap_ab[2], cap_db[2]} !== {6'd4, 32'h0, 6'd5, 32'hDEADBEEF}) begin
      bad++;
      $display("[TB] FAIL mirror_cycle3 got a=%0d/%h b=%0d/%h expected a=4/00000000 b=5/deadbeef",
               cap_aa[2], cap_da[2], cap_ab[2], cap_db[2]);
    end
    total++;
    if ({cap_aa[3], cap_da[3]} !== {6'd6, 32'h12345678}) begin
      bad++;
      $display("[TB] FAIL mirror_cycle4 got a=%0d/%h expected a=6/12345678", cap_aa[3], cap_da[3]);
    end
  endtask

  task automatic test_collision();
    core_write(1, 6'd10, 32'h1, 1, 6'd10, 32'h2);
    run_restore(0, 0, 0, 0, 0, 0, -1);
    total++;
    if ({cap_aa[5], cap_da[5]} !== {6'd10, 32'h2}) begin
      bad++;
      $display("[TB] FAIL collision got x%0d=%h expected x10=00000002", cap_aa[5], cap_da[5]);
    end
  endtask

  task automatic test_x0();
    core_write(1, 6'd0, 32'hFFFFFFFF, 0, 0, 0);
    core_write(0, 0, 0, 1, 6'd0, 32'hFFFFFFFF);
    run_restore(0, 0, 0, 0, 0, 0, -1);
    total++;
    if ({cap_aa[0], cap_da[0]} !== {6'd0, 32'h0}) begin
      bad++;
      $display("[TB] FAIL x0_dropped got x%0d=%h expected x0=00000000", cap_aa[0], cap_da[0]);
    end
  endtask

  task automatic test_same_cycle();
    run_restore(1, 6'd2, 32'h2222_0002, 1, 6'd1, 32'hCAFEF00D, -1);
    total++;
    if (cap_db[0] !== 32'hCAFEF00D || cap_da[1] !== 32'h2222_0002) begin
      bad++;
      $display("[TB] FAIL same_cycle_capture got x1=%h x2=%h expected x1=cafef00d x2=22220002",
               cap_db[0], cap_da[1]);
    end
  endtask

  task automatic test_pulse_ignore();
    int late_rec;
    run_restore(0, 0, 0, 0, 0, 0, 5);
    total++;
    if (rec_n !== 32 || busy_n !== 33 || done_n !== 1) begin
      bad++;
      $display("[TB] FAIL pulse_lengths got rec=%0d busy=%0d done=%0d expected 32/33/1",
               rec_n, busy_n, done_n);
    end
    late_rec = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      if (recover_o || busy_o) late_rec++;
    end
    @(posedge clk_i); #1;
    total++;
    if (late_rec !== 0) begin
      bad++;
      $display("[TB] FAIL ignored_req got %0d active cycles expected 0", late_rec);
    end
  endtask

  task automatic test_back_to_back();
    int rises, rec_total, gap, dones;
    logic prev;
    rises = 0; rec_total = 0; gap = 0; dones = 0; prev = 1'b0;
    restore_req_i = 1'b1;
    push_restore();
    push_restore();
    for (int c = 0; c < 80; c++) begin
      @(negedge clk_i);
      if (recover_o && !prev) rises++;
      if (recover_o) rec_total++;
      if (!recover_o && rises == 1) gap++;
      if (done_o) dones++;
      if (rises == 2 && recover_o) restore_req_i = 1'b0;
      prev = recover_o;
    end
    restore_req_i = 1'b0;
    @(posedge clk_i); #1;
    total++;
    if (rises !== 2 || rec_total !== 64 || gap !== 2 || dones !== 2) begin
      bad++;
      $display("[TB] FAIL back_to_back got rises=%0d rec=%0d gap=%0d done=%0d expected 2/64/2/2",
               rises, rec_total, gap, dones);
    end
  endtask

  task automatic test_reset_mid();
    restore_req_i = 1'b1;
    push_restore();
    @(posedge clk_i); #1;
    restore_req_i = 1'b0;
    repeat (9) @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    exp_q.delete();
    for (int i = 0; i < NR; i++) model[i] = '0;
    #1;
    total++;
    if ({recover_o, rf_we_a_o, rf_waddr_a_o, rf_wdata_a_o, rf_we_b_o, rf_waddr_b_o,
         rf_wdata_b_o, busy_o, done_o} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_mid_outputs got rec=%b we=%b%b busy=%b expected all 0",
               recover_o, rf_we_a_o, rf_we_b_o, busy_o);
    end
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    run_restore(0, 0, 0, 0, 0, 0, -1);
    total++;
    if (cap_db[2] !== 32'h0 || cap_da[5] !== 32'h0 || rec_n !== 32) begin
      bad++;
      $display("[TB] FAIL shadow_cleared got x5=%h x10=%h rec=%0d expected 0/0/32",
               cap_db[2], cap_da[5], rec_n);
    end
  endtask

`ifdef CV32E40P_RF_SHADOW_PARITY_EN
  task automatic test_parity();
    total++;
    if (parity_err_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL parity_clean got %b expected 0", parity_err_o);
    end
    core_write(1, 6'd7, 32'h0F0F0F0F, 0, 0, 0);
    dut.u_mem.mem_q[7][0] = ~dut.u_mem.mem_q[7][0];
    model[7] = 32'h0F0F0F0E;
    run_restore(0, 0, 0, 0, 0, 0, -1);
    total++;
    if (parity_err_o !== 1'b1) begin
      bad++;
      $display("[TB] FAIL parity_detect got %b expected 1", parity_err_o);
    end
    core_write(1, 6'd7, 32'h0000_0007, 0, 0, 0);
    run_restore(0, 0, 0, 0, 0, 0, -1);
    total++;
    if (parity_err_o !== 1'b1) begin
      bad++;
      $display("[TB] FAIL parity_sticky got %b expected 1", parity_err_o);
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < NR; i++) model[i] = '0;
    test_reset();
    test_mirror();
    test_collision();
    test_x0();
    test_same_cycle();
    test_pulse_ignore();
    test_back_to_back();
    test_reset_mid();
`ifdef CV32E40P_RF_SHADOW_PARITY_EN
    test_parity();
`endif
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("[TB] FAIL leftover_beats got %0d expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
